mem_port_arbiter: RTL and testbench

Shares the single unified memory port of `riscv_cpu` between the IF-stage instruction fetch and the MEM-stage load/store unit. It holds one transaction in flight, routes the response back to its owner, and gives data accesses priority, with an optional anti-starvation guard for fetch. It also drops fetch responses killed by a pipeline flush. It sits between the pipeline stages and the memory model sized by `MEM_SIZE_BYTES`.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_starve_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline types for the unified memory port arbiter.
// Widths here match the default XLEN/ADDR_W of the arbiter.
package mem_port_arbiter_pkg;

    localparam int MA_XLEN   = 32;
    localparam int MA_ADDR_W = 32;

    typedef enum logic {
        ARB,
        WAIT
    } mem_arb_state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } mem_arb_owner_e;

    typedef struct packed {
        logic                   we;
        logic [MA_ADDR_W-1:0]   addr;
        logic [MA_XLEN-1:0]     wdata;
        logic [MA_XLEN/8-1:0]   wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and backend signals of the shared memory port.
// slave is the arbiter's view, master the pipeline/backend view.
interface mem_port_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_kill;
    logic              i_gnt;
    logic              i_rvalid;
    logic [XLEN-1:0]   i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr, i_kill,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr, i_kill,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch anti-starvation counter: forces fetch after LIMIT data
// grants taken while fetch was waiting.
module mem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_i
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_gnt || (arb && !i_req)) begin
            cnt_q <= '0;
        end else if (d_gnt && i_req && cnt_q != LIM) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign force_i = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the unified memory port (fetch vs. data).
// Define MEM_ARB_STARVE_GUARD_EN to enable the fetch anti-starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN         = MA_XLEN,
    parameter int ADDR_W       = MA_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT out of range 1..15");
    end

    mem_arb_state_e state_q, state_d;
    mem_arb_owner_e owner_q, owner_d;
    logic           drop_q, drop_d;

    logic     arb, wt, any, sel_d, force_i;
    logic     i_gnt, d_gnt, i_rv, d_rv;
    mem_req_t sel;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb     (arb),
        .i_req   (bus.i_req),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt),
        .force_i (force_i)
    );
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            owner_q <= OWN_I;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are qualified with rst_n so they read 0 during reset.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        sel     = '0;
        arb     = rst_n && state_q == ARB;
        wt      = rst_n && state_q == WAIT;
        any     = bus.i_req | bus.d_req;
        sel_d   = bus.d_req & ~(force_i & bus.i_req);
        if (arb && any) begin
            if (sel_d) begin
                sel.we    = bus.d_we;
                sel.addr  = bus.d_addr;
                sel.wdata = bus.d_wdata;
                sel.wstrb = bus.d_wstrb;
            end else begin
                sel.addr  = bus.i_addr;
            end
        end
        i_gnt = arb & bus.mem_gnt & bus.i_req & ~sel_d;
        d_gnt = arb & bus.mem_gnt & sel_d;
        i_rv  = wt & bus.mem_rvalid & (owner_q == OWN_I)
              & ~drop_q & ~bus.i_kill;
        d_rv  = wt & bus.mem_rvalid & (owner_q == OWN_D);
        unique case (state_q)
            ARB: begin
                if (i_gnt || d_gnt) begin
                    state_d = WAIT;
                    owner_d = d_gnt ? OWN_D : OWN_I;
                    drop_d  = 1'b0;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = ARB;
                    drop_d  = 1'b0;
                end else if (bus.i_kill && owner_q == OWN_I) begin
                    drop_d  = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign bus.mem_req   = arb & any;
    assign bus.mem_we    = sel.we;
    assign bus.mem_addr  = sel.addr;
    assign bus.mem_wdata = sel.wdata;
    assign bus.mem_wstrb = sel.wstrb;
    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.i_rvalid  = i_rv;
    assign bus.d_rvalid  = d_rv;
    assign bus.i_rdata   = i_rv ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rv ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: ARB-state vector table
// plus directed multi-cycle sequences.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32), .ADDR_W(32)) bus ();

    mem_port_arbiter #(
        .XLEN         (32),
        .ADDR_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  ds;
        logic        mg;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_ws;
        logic        e_ig;
        logic        e_dg;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req = 0; bus.i_addr = 0; bus.i_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".mem_req"}, 64'(bus.mem_req), 0);
        chk({nm, ".mem_addr"}, 64'(bus.mem_addr), 0);
        chk({nm, ".mem_we"}, 64'(bus.mem_we), 0);
        chk({nm, ".i_gnt"}, 64'(bus.i_gnt), 0);
        chk({nm, ".d_gnt"}, 64'(bus.d_gnt), 0);
        chk({nm, ".i_rvalid"}, 64'(bus.i_rvalid), 0);
        chk({nm, ".d_rvalid"}, 64'(bus.d_rvalid), 0);
        chk({nm, ".d_rdata"}, 64'(bus.d_rdata), 0);
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 0, 0, 1,
                  0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 32'h100, 0, 0, 0, 0, 0, 1,
                  1, 0, 32'h100, 0, 0, 1, 0};
        vt[2] = '{1, 32'h104, 1, 0, 32'h200, 0, 0, 1,
                  1, 0, 32'h200, 0, 0, 0, 1};
        vt[3] = '{0, 0, 1, 1, 32'h300, 32'h12345678, 4'hF, 1,
                  1, 1, 32'h300, 32'h12345678, 4'hF, 0, 1};
        vt[4] = '{1, 32'h108, 1, 1, 32'h204, 32'h55, 4'h3, 0,
                  1, 1, 32'h204, 32'h55, 4'h3, 0, 0};
        vt[5] = '{1, 32'h10C, 0, 0, 0, 0, 0, 0,
                  1, 0, 32'h10C, 0, 0, 0, 0};
        vt[6] = '{1, 32'h110, 0, 1, 32'h999, 32'hFFFF, 4'hC, 1,
                  1, 0, 32'h110, 0, 0, 1, 0};

        idle();
        bus.i_req = 1; bus.i_addr = 32'h40; bus.mem_gnt = 1;
        #2;
        chk_all_zero("reset");
        idle();
        tick();
        rst_n = 1;

        foreach (vt[n]) begin
            tick();
            bus.i_req = vt[n].ir; bus.i_addr = vt[n].ia;
            bus.d_req = vt[n].dr; bus.d_we = vt[n].dwe;
            bus.d_addr = vt[n].da; bus.d_wdata = vt[n].dwd;
            bus.d_wstrb = vt[n].ds; bus.mem_gnt = vt[n].mg;
            @(negedge clk);
            chk($sformatf("v%0d.mem_req", n), 64'(bus.mem_req), 64'(vt[n].e_req));
            chk($sformatf("v%0d.mem_we", n), 64'(bus.mem_we), 64'(vt[n].e_we));
            chk($sformatf("v%0d.mem_addr", n), 64'(bus.mem_addr), 64'(vt[n].e_addr));
            chk($sformatf("v%0d.mem_wdata", n), 64'(bus.mem_wdata), 64'(vt[n].e_wd));
            chk($sformatf("v%0d.mem_wstrb", n), 64'(bus.mem_wstrb), 64'(vt[n].e_ws));
            chk($sformatf("v%0d.i_gnt", n), 64'(bus.i_gnt), 64'(vt[n].e_ig));
            chk($sformatf("v%0d.d_gnt", n), 64'(bus.d_gnt), 64'(vt[n].e_dg));
            if (vt[n].e_ig || vt[n].e_dg) begin
                tick();
                idle();
                bus.mem_rvalid = 1;
                bus.mem_rdata = 32'hA5A50000 + 32'(n);
                @(negedge clk);
                chk($sformatf("v%0d.i_rvalid", n), 64'(bus.i_rvalid), 64'(vt[n].e_ig));
                chk($sformatf("v%0d.d_rvalid", n), 64'(bus.d_rvalid), 64'(vt[n].e_dg));
                chk($sformatf("v%0d.d_rdata", n), 64'(bus.d_rdata),
                    vt[n].e_dg ? 64'(32'hA5A50000 + 32'(n)) : 64'd0);
                tick();
                bus.mem_rvalid = 0;
            end
            idle();
        end

        // Lone fetch with a 3-cycle response
        tick();
        bus.i_req = 1; bus.i_addr = 32'h100; bus.mem_gnt = 1;
        @(negedge clk);
        chk("fetch.i_gnt", 64'(bus.i_gnt), 1);
        chk("fetch.d_gnt", 64'(bus.d_gnt), 0);
        tick();
        bus.i_req = 0; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("fetch.c1_mem_req", 64'(bus.mem_req), 0);
        chk("fetch.c1_i_rdata", 64'(bus.i_rdata), 0);
        tick();
        @(negedge clk);
        chk("fetch.c2_i_rvalid", 64'(bus.i_rvalid), 0);
        tick();
        bus.mem_rvalid = 1;
        @(negedge clk);
        chk("fetch.i_rvalid", 64'(bus.i_rvalid), 1);
        chk("fetch.i_rdata", 64'(bus.i_rdata), 64'h DEADBEEF);
        chk("fetch.d_rvalid", 64'(bus.d_rvalid), 0);
        tick();
        idle();

        // Simultaneous requests: data first, fetch after the response
        tick();
        bus.mem_gnt = 1;
        bus.i_req = 1; bus.i_addr = 32'h104;
        bus.d_req = 1; bus.d_addr = 32'h200;
        @(negedge clk);
        chk("simul.d_gnt", 64'(bus.d_gnt), 1);
        chk("simul.i_gnt0", 64'(bus.i_gnt), 0);
        chk("simul.mem_addr_d", 64'(bus.mem_addr), 64'h200);
        tick();
        bus.d_req = 0;
        @(negedge clk);
        chk("simul.wait_i_gnt", 64'(bus.i_gnt), 0);
        chk("simul.wait_mem_req", 64'(bus.mem_req), 0);
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        chk("simul.d_rvalid", 64'(bus.d_rvalid), 1);
        chk("simul.d_rdata", 64'(bus.d_rdata), 64'hCAFE0001);
        chk("simul.i_rvalid0", 64'(bus.i_rvalid), 0);
        chk("simul.i_gnt_rsp", 64'(bus.i_gnt), 0);
        tick();
        bus.mem_rvalid = 0;
        @(negedge clk);
        chk("simul.i_gnt", 64'(bus.i_gnt), 1);
        chk("simul.mem_addr_i", 64'(bus.mem_addr), 64'h104);
        tick();
        bus.i_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h11;
        @(negedge clk);
        chk("simul.i_rvalid", 64'(bus.i_rvalid), 1);
        tick();
        idle();

        // Kill one cycle after grant, response two cycles later
        tick();
        bus.mem_gnt = 1; bus.i_req = 1; bus.i_addr = 32'h108;
        @(negedge clk);
        chk("kill.i_gnt", 64'(bus.i_gnt), 1);
        tick();
        bus.i_req = 0; bus.i_kill = 1;
        tick();
        bus.i_kill = 0;
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
        @(negedge clk);
        chk("kill.i_rvalid", 64'(bus.i_rvalid), 0);
        chk("kill.i_rdata", 64'(bus.i_rdata), 0);
        tick();
        bus.mem_rvalid = 0; bus.d_req = 1; bus.d_addr = 32'h204;
        @(negedge clk);
        chk("kill.d_gnt_after", 64'(bus.d_gnt), 1);
        tick();
        bus.d_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h88;
        @(negedge clk);
        chk("kill.d_rvalid", 64'(bus.d_rvalid), 1);
        tick();
        idle();

        // Kill in the same cycle as the response
        tick();
        bus.mem_gnt = 1; bus.i_req = 1; bus.i_addr = 32'h10C;
        tick();
        bus.i_req = 0; bus.i_kill = 1; bus.mem_rvalid = 1;
        bus.mem_rdata = 32'h99;
        @(negedge clk);
        chk("kill_same.i_rvalid", 64'(bus.i_rvalid), 0);
        tick();
        idle();

        // Stray response while idle in ARB
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
        @(negedge clk);
        chk("stray.i_rvalid", 64'(bus.i_rvalid), 0);
        chk("stray.d_rvalid", 64'(bus.d_rvalid), 0);
        tick();
        idle();

        // Continuous data traffic alongside a waiting fetch
        tick();
        bus.mem_gnt = 1;
        bus.i_req = 1; bus.i_addr = 32'h400;
        bus.d_req = 1; bus.d_addr = 32'h500;
        for (int k = 1; k <= 6; k++) begin
            logic exp_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = (k == 5);
`else
            exp_i = 1'b0;
`endif
            @(negedge clk);
            chk($sformatf("starve.g%0d.i_gnt", k), 64'(bus.i_gnt), 64'(exp_i));
            chk($sformatf("starve.g%0d.d_gnt", k), 64'(bus.d_gnt), 64'(!exp_i));
            tick();
            bus.mem_rvalid = 1;
            tick();
            bus.mem_rvalid = 0;
        end
        idle();

        // Asynchronous reset while a fetch is outstanding
        tick();
        bus.mem_gnt = 1; bus.i_req = 1; bus.i_addr = 32'h600;
        tick();
        #2;
        rst_n = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD;
        #1;
        chk_all_zero("rst_wait");
        chk("rst_wait.i_rdata", 64'(bus.i_rdata), 0);
        tick();
        bus.mem_rvalid = 0;
        rst_n = 1;
        bus.i_addr = 32'h700;
        @(negedge clk);
        chk("rst_after.i_gnt", 64'(bus.i_gnt), 1);
        chk("rst_after.mem_addr", 64'(bus.mem_addr), 64'h700);
        tick();
        bus.i_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h5A5A;
        @(negedge clk);
        chk("rst_after.i_rvalid", 64'(bus.i_rvalid), 1);
        tick();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
